fma_read_buffer: RTL and testbench

Read-side counterpart of the FMA write buffer: accepts packed memory lines and unpacks each into successive phrases of one word per FMA, presented to the FMA array with a valid/ready handshake. It sits between shared memory and the FMA operand inputs. It absorbs memory latency with a 2-line queue. A per-word mask lets memory mark unused slots, and phrases whose slots are all masked are skipped.

---
 rtl/fma_pkg.sv | 20 ++
 rtl/fma_line_fifo.sv | 47 ++++
 rtl/fma_read_buffer.sv | 104 ++++++++++
 tb/tb_fma_read_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Constants and types shared by the FMA line buffers: phrase count, phrase
// index type and the slot-index mapping used to pack/unpack memory lines.
package fma_pkg;

    localparam int unsigned PHRASE_COUNT = 3;
    localparam int unsigned PHRASE_BITS  = 2;

    typedef logic [PHRASE_BITS-1:0] phrase_t;

    localparam phrase_t FIRST_PHRASE = phrase_t'(0);
    localparam phrase_t LAST_PHRASE  = phrase_t'(PHRASE_COUNT - 1);

    // Slot of (phrase, fma) within a line; also the bit index in the line mask.
    function automatic int unsigned slot_index(input int unsigned phrase,
                                               input int unsigned fma,
                                               input int unsigned fma_count);
        return phrase * fma_count + fma;
    endfunction

endpackage

// File: rtl/fma_line_fifo.sv
// Two-entry synchronous FIFO holding {mask, line} entries; the head entry is
// exposed combinationally. Callers must not push when full or pop when empty.
module fma_line_fifo #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_idx;
    logic                  wr_idx;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx <= 1'b0;
            wr_idx <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_idx];

endmodule

// File: rtl/fma_read_buffer.sv
// Unpacks queued memory lines into per-FMA phrases, skipping phrases whose
// slots are all masked, and presents them with a valid/ready handshake.
module fma_read_buffer
    import fma_pkg::*;
#(
    parameter int unsigned FMA_COUNT  = 2,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 96
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [LINE_WIDTH-1:0]             line_in,
    input  logic [PHRASE_COUNT*FMA_COUNT-1:0] line_mask_in,
    input  logic                              line_valid_in,
    output logic                              line_ready_out,
    output logic [WORD_WIDTH*FMA_COUNT-1:0]   word_out,
    output logic [FMA_COUNT-1:0]              word_valid_out,
    output phrase_t                           phrase_out_num,
    input  logic                              word_ready_in
);

    localparam int unsigned MASK_WIDTH  = PHRASE_COUNT * FMA_COUNT;
    localparam int unsigned ENTRY_WIDTH = LINE_WIDTH + MASK_WIDTH;

    logic [ENTRY_WIDTH-1:0] head_entry;
    logic [LINE_WIDTH-1:0]  head_line;
    logic [MASK_WIDTH-1:0]  head_mask;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;
    logic                   have_head;
    logic                   found;
    logic                   more;
    logic                   transfer;
    phrase_t                ptr;
    phrase_t                cur;

    assign line_ready_out = (count < 2'd2) && !rst_in;
    assign push           = line_valid_in && line_ready_out;

    fma_line_fifo #(
        .DATA_WIDTH(ENTRY_WIDTH)
    ) u_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (push),
        .push_data({line_mask_in, line_in}),
        .pop      (pop),
        .head_data(head_entry),
        .count    (count)
    );

    assign head_line = head_entry[LINE_WIDTH-1:0];
    assign head_mask = head_entry[ENTRY_WIDTH-1:LINE_WIDTH];
    assign have_head = (count != 2'd0);

    // cur is the first populated phrase at or above ptr; more flags any later one.
    always_comb begin
        found = 1'b0;
        more  = 1'b0;
        cur   = FIRST_PHRASE;
        for (int unsigned p = 0; p < PHRASE_COUNT; p++) begin
            if ((head_mask[p*FMA_COUNT +: FMA_COUNT] != '0) && (phrase_t'(p) >= ptr)) begin
                if (found) begin
                    more = 1'b1;
                end else begin
                    found = 1'b1;
                    cur   = phrase_t'(p);
                end
            end
        end
    end

    always_comb begin
        word_out       = '0;
        word_valid_out = '0;
        phrase_out_num = FIRST_PHRASE;
        if (have_head && found) begin
            phrase_out_num = cur;
            for (int unsigned f = 0; f < FMA_COUNT; f++) begin
                if (head_mask[slot_index(int'(cur), f, FMA_COUNT)]) begin
                    word_valid_out[f]                  = 1'b1;
                    word_out[f*WORD_WIDTH +: WORD_WIDTH] =
                        head_line[slot_index(int'(cur), f, FMA_COUNT)*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // A head with nothing left to present is dropped without an output cycle.
    assign transfer = have_head && found && word_ready_in;
    assign pop      = have_head && (!found || (word_ready_in && !more));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr <= FIRST_PHRASE;
        end else if (pop) begin
            ptr <= FIRST_PHRASE;
        end else if (transfer) begin
            ptr <= (cur == LAST_PHRASE) ? FIRST_PHRASE : cur + phrase_t'(1);
        end
    end

endmodule

// File: tb/tb_fma_read_buffer.sv
// Directed and randomized checks of fma_read_buffer against a queue-of-lines
// model tracking, per line, the set of phrases still to be presented.
module tb_fma_read_buffer;

    localparam int unsigned FC = 2;
    localparam int unsigned WW = 16;
    localparam int unsigned LW = 96;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [LW-1:0] line_in;
    logic [5:0]    line_mask_in;
    logic          line_valid_in;
    logic          line_ready_out;
    logic [31:0]   word_out;
    logic [1:0]    word_valid_out;
    logic [1:0]    phrase_out_num;
    logic          word_ready_in;

    fma_read_buffer #(
        .FMA_COUNT (FC),
        .WORD_WIDTH(WW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .line_in       (line_in),
        .line_mask_in  (line_mask_in),
        .line_valid_in (line_valid_in),
        .line_ready_out(line_ready_out),
        .word_out      (word_out),
        .word_valid_out(word_valid_out),
        .phrase_out_num(phrase_out_num),
        .word_ready_in (word_ready_in)
    );

    always #5 clk_in = ~clk_in;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [LW-1:0] q_line [$];
    logic [5:0]    q_mask [$];
    logic [2:0]    q_rem  [$];

    logic [31:0] obs_word;
    logic [1:0]  obs_val;
    logic [1:0]  obs_num;
    logic        obs_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] phrases_of(input logic [5:0] mk);
        logic [2:0] r;
        for (int p = 0; p < 3; p++) r[p] = |mk[p*2 +: 2];
        return r;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic step(input logic v, input logic [LW-1:0] ln, input logic [5:0] mk,
                        input logic rdy, input logic rs);
        logic        e_rdy;
        logic [31:0] e_word;
        logic [1:0]  e_val;
        logic [1:0]  e_num;
        logic [2:0]  r;
        logic [5:0]  hm;
        logic [LW-1:0] hl;
        int          p;
        @(negedge clk_in);
        rst_in        = rs;
        line_valid_in = v;
        line_in       = ln;
        line_mask_in  = mk;
        word_ready_in = rdy;
        #1;
        e_rdy  = !rs && (q_line.size() < 2);
        e_word = '0;
        e_val  = '0;
        e_num  = '0;
        r      = '0;
        p      = 0;
        if (q_line.size() > 0) begin
            r  = q_rem[0];
            hm = q_mask[0];
            hl = q_line[0];
            for (int i = 2; i >= 0; i--) if (r[i]) p = i;
            if (r != 0) begin
                e_num = 2'(p);
                for (int f = 0; f < 2; f++) begin
                    if (hm[p*2 + f]) begin
                        e_val[f]          = 1'b1;
                        e_word[f*16 +: 16] = hl[(p*2 + f)*16 +: 16];
                    end
                end
            end
        end
        check("line_ready_out", 64'(line_ready_out), 64'(e_rdy));
        check("word_valid_out", 64'(word_valid_out), 64'(e_val));
        check("phrase_out_num", 64'(phrase_out_num), 64'(e_num));
        check("word_out", 64'(word_out), 64'(e_word));
        obs_word = word_out;
        obs_val  = word_valid_out;
        obs_num  = phrase_out_num;
        obs_rdy  = line_ready_out;
        @(posedge clk_in);
        if (rs) begin
            q_line.delete();
            q_mask.delete();
            q_rem.delete();
        end else begin
            if (q_line.size() > 0) begin
                if (r == 0) begin
                    void'(q_line.pop_front()); void'(q_mask.pop_front()); void'(q_rem.pop_front());
                end else if (rdy) begin
                    r[p] = 1'b0;
                    if (r == 0) begin
                        void'(q_line.pop_front()); void'(q_mask.pop_front()); void'(q_rem.pop_front());
                    end else begin
                        q_rem[0] = r;
                    end
                end
            end
            if (v && e_rdy) begin
                q_line.push_back(ln);
                q_mask.push_back(mk);
                q_rem.push_back(phrases_of(mk));
            end
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 3; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rand_line(), 6'(($urandom)), rdy, 1'b0);
    endtask

    initial begin
        logic [LW-1:0] seq_line;
        int            shown;
        for (int i = 0; i < 6; i++) seq_line[i*16 +: 16] = 16'(i + 1);

        // Reset and release.
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check("ready_in_reset", 64'(obs_rdy), 64'(0));
        idle(1, 1'b1);
        check("ready_after_reset", 64'(obs_rdy), 64'(1));

        // Full line with words 1..6.
        step(1'b1, seq_line, 6'b111111, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("full_p0_word", 64'(obs_word), 64'h0002_0001);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("full_p1_word", 64'(obs_word), 64'h0004_0003);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("full_p2_word", 64'(obs_word), 64'h0006_0005);
        check("full_p2_num", 64'(obs_num), 64'd2);
        idle(1, 1'b1);

        // Sparse mask: phrase 1 skipped, FMA1 of phrase 0 masked.
        step(1'b1, rand_line(), 6'b110001, 1'b1, 1'b0);
        shown = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            if (obs_val != 0) shown++;
        end
        check("sparse_output_cycles", 64'(shown), 64'd2);

        // Empty line followed by a full line.
        step(1'b1, rand_line(), 6'b000000, 1'b1, 1'b0);
        step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Backpressure while a third line is offered.
        step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, rand_line(), 6'b111111, 1'b0, 1'b0);
        check("held_phrase_num", 64'(obs_num), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        idle(8, 1'b1);

        // Three lines back-to-back, ready high.
        for (int i = 0; i < 3; i++) step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        idle(8, 1'b1);

        // Reset in the middle of a queued line.
        step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        step(1'b1, rand_line(), 6'b111111, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("post_reset_valid", 64'(obs_val), 64'd0);
        check("post_reset_ready", 64'(obs_rdy), 64'd1);
        idle(4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] mk;
            case ($urandom_range(0, 3))
                0:       mk = 6'b111111;
                1:       mk = 6'b000000;
                default: mk = 6'($urandom);
            endcase
            step(1'($urandom), rand_line(), mk, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
